// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_mem_pkg
//  Purpose  : Shared constants for the LC-3 memory/IO responder: memory-mapped
//             device register addresses, device-page prefix, responder FSM
//             state encoding and R_W encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    // Device page occupies xFE00-xFFFF, identified by the top seven MAR bits.
    localparam logic [6:0]  c_DEV_PAGE  = 7'h7F;

    localparam logic [15:0] c_KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] c_KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] c_DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] c_DDR_ADDR  = 16'hFE06;

    // Responder FSM states.
    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_ACCESS = 2'd1;
    localparam logic [1:0]  c_ST_DONE   = 2'd2;

    // R_W encoding on the datapath interface.
    localparam logic        c_RW_READ   = 1'b0;
    localparam logic        c_RW_WRITE  = 1'b1;

endpackage : lc3_mem_pkg
`default_nettype wire

// File: rtl/io_device_regs.sv
`default_nettype none
// ============================================================================
//  Module   : io_device_regs
//  Purpose  : LC-3 memory-mapped device registers (KBSR/KBDR/DSR/DDR):
//             keyboard capture with overrun drop, display valid/ready
//             handshake, read mux and keyboard interrupt request.
//  Ports    : i_clk/i_rst      - clock, synchronous active-high reset
//             i_commit         - one-cycle strobe committing the access below
//             i_addr/i_rw      - latched access address and direction
//             i_wr_ie          - write data bit 14 (KBSR interrupt enable)
//             i_wr_char        - write data bits 7:0 (display character)
//             i_kb_valid/data  - keyboard character strobe and value
//             i_ddr_ready      - display accepts the pending character
//             o_rdata          - zero-extended read data of addressed register
//             o_ddr_valid/data - display character handshake
//             o_kb_int         - KBSR[15] & KBSR[14]
//  Revision : 1.0 - initial release
// ============================================================================
module io_device_regs
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_commit,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_rw,
    input  logic              i_wr_ie,
    input  logic [7:0]        i_wr_char,
    input  logic              i_kb_valid,
    input  logic [7:0]        i_kb_data,
    input  logic              i_ddr_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ddr_valid,
    output logic [7:0]        o_ddr_data,
    output logic              o_kb_int
);

    logic        r_kb_ready;   // KBSR[15]
    logic        r_kb_ie;      // KBSR[14]
    logic [7:0]  r_kbdr;
    logic        r_dsr_ready;  // DSR[15]
    logic        r_ddr_valid;
    logic [7:0]  r_ddr_data;

    logic        w_sel_kbsr;
    logic        w_sel_kbdr;
    logic        w_sel_dsr;
    logic        w_sel_ddr;
    logic        w_kbdr_rd;
    logic        w_kbsr_wr;
    logic        w_ddr_wr;
    logic [15:0] w_rd16;

    assign w_sel_kbsr = (i_addr == ADDR_W'(c_KBSR_ADDR));
    assign w_sel_kbdr = (i_addr == ADDR_W'(c_KBDR_ADDR));
    assign w_sel_dsr  = (i_addr == ADDR_W'(c_DSR_ADDR));
    assign w_sel_ddr  = (i_addr == ADDR_W'(c_DDR_ADDR));

    assign w_kbdr_rd  = i_commit && (i_rw == c_RW_READ)  && w_sel_kbdr;
    assign w_kbsr_wr  = i_commit && (i_rw == c_RW_WRITE) && w_sel_kbsr;
    // A display write only takes effect when the display is ready.
    assign w_ddr_wr   = i_commit && (i_rw == c_RW_WRITE) && w_sel_ddr && r_dsr_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_kb_ready  <= 1'b0;
            r_kb_ie     <= 1'b0;
            r_kbdr      <= 8'h00;
            r_dsr_ready <= 1'b1;
            r_ddr_valid <= 1'b0;
            r_ddr_data  <= 8'h00;
        end else begin
            // A character arriving in the same cycle as the KBDR read that
            // empties the buffer is accepted, so the ready flag stays set.
            if (i_kb_valid && (!r_kb_ready || w_kbdr_rd)) begin
                r_kbdr     <= i_kb_data;
                r_kb_ready <= 1'b1;
            end else if (w_kbdr_rd) begin
                r_kb_ready <= 1'b0;
            end

            if (w_kbsr_wr) begin
                r_kb_ie <= i_wr_ie;
            end

            // r_dsr_ready and r_ddr_valid are mutually exclusive, so these
            // two branches can never both apply.
            if (w_ddr_wr) begin
                r_ddr_data  <= i_wr_char;
                r_ddr_valid <= 1'b1;
                r_dsr_ready <= 1'b0;
            end else if (r_ddr_valid && i_ddr_ready) begin
                r_ddr_valid <= 1'b0;
                r_dsr_ready <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rd16 = 16'h0000;
        if (w_sel_kbsr) begin
            w_rd16 = {r_kb_ready, r_kb_ie, 14'd0};
        end else if (w_sel_kbdr) begin
            w_rd16 = {8'h00, r_kbdr};
        end else if (w_sel_dsr) begin
            w_rd16 = {r_dsr_ready, 15'd0};
        end else if (w_sel_ddr) begin
            w_rd16 = {8'h00, r_ddr_data};
        end
    end

    assign o_rdata     = DATA_W'(w_rd16);
    assign o_ddr_valid = r_ddr_valid;
    assign o_ddr_data  = r_ddr_data;
    assign o_kb_int    = r_kb_ready & r_kb_ie;

endmodule : io_device_regs
`default_nettype wire

// File: rtl/memory_io.sv
`default_nettype none
// ============================================================================
//  Module   : memory_io
//  Purpose  : LC-3 memory/IO responder answering the microsequencer's
//             MIO_EN/R handshake. Each request runs WAIT_STATES ACCESS cycles
//             against either an external synchronous RAM or the device
//             registers, then holds o_R_Bit until MIO_EN is released.
//  Ports    : i_CLK/i_Reset         - clock, synchronous active-high reset
//             i_MIO_EN/i_R_W        - request and direction (1 = write)
//             i_MAR/i_MDR           - access address and write data
//             o_R_Bit/o_Mem_Data    - completion flag and captured read data
//             o_Mem_EN/WE/Addr/Wdata, i_Mem_Rdata - synchronous RAM port
//             i_KB_Valid/i_KB_Data  - keyboard character input
//             o_DDR_Valid/o_DDR_Data/i_DDR_Ready - display handshake
//             o_KB_INT              - keyboard interrupt request
//  Revision : 1.0 - initial release
// ============================================================================
module memory_io
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              i_CLK,
    input  logic              i_Reset,
    input  logic              i_MIO_EN,
    input  logic              i_R_W,
    input  logic [ADDR_W-1:0] i_MAR,
    input  logic [DATA_W-1:0] i_MDR,
    output logic              o_R_Bit,
    output logic [DATA_W-1:0] o_Mem_Data,
    output logic              o_Mem_EN,
    output logic              o_Mem_WE,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_Wdata,
    input  logic [DATA_W-1:0] i_Mem_Rdata,
    input  logic              i_KB_Valid,
    input  logic [7:0]        i_KB_Data,
    output logic              o_DDR_Valid,
    output logic [7:0]        o_DDR_Data,
    input  logic              i_DDR_Ready,
    output logic              o_KB_INT
);

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_STATES);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              r_rw;
    logic              r_dev;
    logic              r_r_bit;
    logic [DATA_W-1:0] r_mem_data;

    logic              w_req_dev;
    logic              w_first;
    logic              w_last;
    logic              w_dev_commit;
    logic [DATA_W-1:0] w_dev_rdata;

    assign w_req_dev    = (i_MAR[ADDR_W-1 -: 7] == c_DEV_PAGE);
    assign w_first      = (r_state == c_ST_ACCESS) && (r_cnt == c_WAIT_LOAD);
    // The final ACCESS cycle only completes if the request is still held;
    // a dropped MIO_EN in that cycle is an abort with no side effects.
    assign w_last       = (r_state == c_ST_ACCESS) && (r_cnt == 4'd1) && i_MIO_EN;
    assign w_dev_commit = w_last && r_dev;

    // The RAM strobe depends only on the first ACCESS cycle, so a write
    // issued there stands even if the request is later aborted.
    assign o_Mem_EN    = w_first && !r_dev;
    assign o_Mem_WE    = o_Mem_EN && (r_rw == c_RW_WRITE);
    assign o_Mem_Addr  = r_mar;
    assign o_Mem_Wdata = r_mdr;
    assign o_R_Bit     = r_r_bit;
    assign o_Mem_Data  = r_mem_data;

    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= 4'd0;
            r_mar      <= '0;
            r_mdr      <= '0;
            r_rw       <= c_RW_READ;
            r_dev      <= 1'b0;
            r_r_bit    <= 1'b0;
            r_mem_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_MIO_EN) begin
                        r_mar   <= i_MAR;
                        r_mdr   <= i_MDR;
                        r_rw    <= i_R_W;
                        r_dev   <= w_req_dev;
                        r_cnt   <= c_WAIT_LOAD;
                        r_state <= c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    if (!i_MIO_EN) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (w_last) begin
                            // RAM data is valid here because the strobe was
                            // at least one cycle earlier (WAIT_STATES >= 2).
                            if (r_rw == c_RW_READ) begin
                                r_mem_data <= r_dev ? w_dev_rdata : i_Mem_Rdata;
                            end
                            r_r_bit <= 1'b1;
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    if (!i_MIO_EN) begin
                        r_r_bit <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    io_device_regs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_io_device_regs (
        .i_clk       (i_CLK),
        .i_rst       (i_Reset),
        .i_commit    (w_dev_commit),
        .i_addr      (r_mar),
        .i_rw        (r_rw),
        .i_wr_ie     (r_mdr[14]),
        .i_wr_char   (r_mdr[7:0]),
        .i_kb_valid  (i_KB_Valid),
        .i_kb_data   (i_KB_Data),
        .i_ddr_ready (i_DDR_Ready),
        .o_rdata     (w_dev_rdata),
        .o_ddr_valid (o_DDR_Valid),
        .o_ddr_data  (o_DDR_Data),
        .o_kb_int    (o_KB_INT)
    );

endmodule : memory_io
`default_nettype wire

// File: tb/tb_memory_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_io
//  Purpose  : Self-checking bench for memory_io with an attached RAM and a
//             behavioural model of the memory map and devices.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_io;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_MIO_EN = 1'b0;
    logic        i_R_W = 1'b0;
    logic [15:0] i_MAR = 16'h0000;
    logic [15:0] i_MDR = 16'h0000;
    logic        o_R_Bit;
    logic [15:0] o_Mem_Data;
    logic        o_Mem_EN;
    logic        o_Mem_WE;
    logic [15:0] o_Mem_Addr;
    logic [15:0] o_Mem_Wdata;
    logic [15:0] i_Mem_Rdata = 16'h0000;
    logic        i_KB_Valid = 1'b0;
    logic [7:0]  i_KB_Data = 8'h00;
    logic        o_DDR_Valid;
    logic [7:0]  o_DDR_Data;
    logic        i_DDR_Ready = 1'b0;
    logic        o_KB_INT;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_io #(.WAIT_STATES(WS), .ADDR_W(16), .DATA_W(16)) dut (
        .i_CLK(clk), .i_Reset(i_Reset), .i_MIO_EN(i_MIO_EN), .i_R_W(i_R_W),
        .i_MAR(i_MAR), .i_MDR(i_MDR), .o_R_Bit(o_R_Bit), .o_Mem_Data(o_Mem_Data),
        .o_Mem_EN(o_Mem_EN), .o_Mem_WE(o_Mem_WE), .o_Mem_Addr(o_Mem_Addr),
        .o_Mem_Wdata(o_Mem_Wdata), .i_Mem_Rdata(i_Mem_Rdata),
        .i_KB_Valid(i_KB_Valid), .i_KB_Data(i_KB_Data),
        .o_DDR_Valid(o_DDR_Valid), .o_DDR_Data(o_DDR_Data),
        .i_DDR_Ready(i_DDR_Ready), .o_KB_INT(o_KB_INT)
    );

    // Attached synchronous RAM: one-cycle read latency.
    logic [15:0] tb_ram [0:65535];
    always @(posedge clk) begin
        if (o_Mem_EN === 1'b1) begin
            if (o_Mem_WE === 1'b1) tb_ram[o_Mem_Addr] <= o_Mem_Wdata;
            else                   i_Mem_Rdata <= tb_ram[o_Mem_Addr];
        end
    end

    // Behavioural model of the memory map.
    logic [15:0] m_ram [int];
    bit          m_kb_full, m_kb_ie, m_dsr_rdy, m_ddr_valid;
    logic [7:0]  m_kbdr, m_ddr_data;

    task automatic model_reset();
        m_kb_full = 0; m_kb_ie = 0; m_kbdr = 8'h00;
        m_dsr_rdy = 1; m_ddr_valid = 0; m_ddr_data = 8'h00;
    endtask

    task automatic model_access(input bit rw, input logic [15:0] a,
                                input logic [15:0] wd, output logic [15:0] rd);
        rd = 16'h0000;
        if (a >= 16'hFE00) begin
            case (a)
                16'hFE00: if (rw) m_kb_ie = wd[14]; else rd = {m_kb_full, m_kb_ie, 14'd0};
                16'hFE02: if (!rw) begin rd = {8'h00, m_kbdr}; m_kb_full = 0; end
                16'hFE04: if (!rw) rd = {m_dsr_rdy, 15'd0};
                16'hFE06: begin
                    if (rw) begin
                        if (m_dsr_rdy) begin
                            m_ddr_data = wd[7:0]; m_ddr_valid = 1; m_dsr_rdy = 0;
                        end
                    end else begin
                        rd = {8'h00, m_ddr_data};
                    end
                end
                default: ;
            endcase
        end else if (rw) begin
            m_ram[a] = wd;
        end else begin
            rd = m_ram.exists(a) ? m_ram[a] : 16'h0000;
        end
    endtask

    task automatic model_kb(input logic [7:0] d);
        if (!m_kb_full) begin m_kbdr = d; m_kb_full = 1; end
    endtask

    task automatic model_ack();
        if (m_ddr_valid) begin m_ddr_valid = 0; m_dsr_rdy = 1; end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_side();
        check("ddr_valid", {31'd0, o_DDR_Valid}, {31'd0, m_ddr_valid});
        check("ddr_data", {24'd0, o_DDR_Data}, {24'd0, m_ddr_data});
        check("kb_int", {31'd0, o_KB_INT}, {31'd0, (m_kb_full & m_kb_ie)});
    endtask

    // Full handshake: request, wait for R, optionally hold, release.
    // inj places a keyboard strobe on the commit cycle of the access.
    task automatic op(input bit rw, input logic [15:0] a, input logic [15:0] wd,
                      input int hold, input bit inj, input logic [7:0] injd,
                      output logic [15:0] rd);
        int cyc = 0;
        int en_cnt = 0;
        int en_cyc = -1;
        bit dev = (a >= 16'hFE00);
        logic [15:0] exp_rd;
        i_MIO_EN = 1; i_R_W = rw; i_MAR = a; i_MDR = wd;
        while (o_R_Bit !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            i_KB_Valid = 0;
            if (o_Mem_EN === 1'b1) begin
                en_cnt++;
                if (en_cyc < 0) en_cyc = cyc;
                check("mem_addr", {16'd0, o_Mem_Addr}, {16'd0, a});
                check("mem_we", {31'd0, o_Mem_WE}, {31'd0, rw});
                if (rw) check("mem_wdata", {16'd0, o_Mem_Wdata}, {16'd0, wd});
            end
            if (inj && cyc == WS) begin i_KB_Valid = 1; i_KB_Data = injd; end
        end
        check("latency", cyc, WS + 1);
        check("mem_en_count", en_cnt, dev ? 0 : 1);
        if (!dev) check("mem_en_cycle", en_cyc, 1);
        model_access(rw, a, wd, exp_rd);
        if (inj) model_kb(injd);
        rd = o_Mem_Data;
        if (!rw) check("rdata", {16'd0, rd}, {16'd0, exp_rd});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("rbit_hold", {31'd0, o_R_Bit}, 32'd1);
        end
        i_MIO_EN = 0; i_R_W = 0;
        @(posedge clk); #1;
        check("rbit_clear", {31'd0, o_R_Bit}, 32'd0);
        check_side();
    endtask

    task automatic kb_char(input logic [7:0] d);
        i_KB_Valid = 1; i_KB_Data = d;
        @(posedge clk); #1;
        i_KB_Valid = 0;
        model_kb(d);
        check_side();
    endtask

    task automatic ddr_ack();
        i_DDR_Ready = 1;
        @(posedge clk); #1;
        i_DDR_Ready = 0;
        model_ack();
        check_side();
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] addrs [0:7];
        bit          seen;
        int          n;

        for (int i = 0; i < 65536; i++) tb_ram[i] = 16'h0000;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rbit", {31'd0, o_R_Bit}, 32'd0);
        check("rst_mem_en", {31'd0, o_Mem_EN}, 32'd0);
        check("rst_mem_we", {31'd0, o_Mem_WE}, 32'd0);
        check("rst_mem_data", {16'd0, o_Mem_Data}, 32'd0);
        check_side();
        i_Reset = 0;
        @(posedge clk); #1;

        // RAM read/write
        op(1, 16'h3000, 16'h1234, 0, 0, 8'h00, rd);
        op(0, 16'h3000, 16'h0000, 1, 0, 8'h00, rd);
        check("ram_read_3000", {16'd0, rd}, 32'h1234);
        op(1, 16'h4000, 16'hBEEF, 0, 0, 8'h00, rd);
        op(0, 16'h4000, 16'h0000, 0, 0, 8'h00, rd);
        check("ram_read_4000", {16'd0, rd}, 32'hBEEF);

        // Keyboard capture and overrun
        kb_char(8'h41);
        op(0, 16'hFE00, 16'h0000, 0, 0, 8'h00, rd);
        check("kbsr_full", {16'd0, rd}, 32'h8000);
        kb_char(8'h42);
        op(0, 16'hFE02, 16'h0000, 0, 0, 8'h00, rd);
        check("kbdr_first", {16'd0, rd}, 32'h0041);
        op(0, 16'hFE00, 16'h0000, 0, 0, 8'h00, rd);
        check("kbsr_empty", {16'd0, rd}, 32'h0000);

        // Display handshake
        op(1, 16'hFE06, 16'h0058, 0, 0, 8'h00, rd);
        check("ddr_valid_set", {31'd0, o_DDR_Valid}, 32'd1);
        check("ddr_data_58", {24'd0, o_DDR_Data}, 32'h58);
        op(0, 16'hFE04, 16'h0000, 0, 0, 8'h00, rd);
        check("dsr_busy", {16'd0, rd}, 32'h0000);
        op(1, 16'hFE06, 16'h0059, 0, 0, 8'h00, rd);
        check("ddr_data_kept", {24'd0, o_DDR_Data}, 32'h58);
        ddr_ack();
        op(0, 16'hFE04, 16'h0000, 0, 0, 8'h00, rd);
        check("dsr_ready", {16'd0, rd}, 32'h8000);

        // Interrupt
        op(1, 16'hFE00, 16'h4000, 0, 0, 8'h00, rd);
        kb_char(8'h55);
        check("kb_int_set", {31'd0, o_KB_INT}, 32'd1);
        op(0, 16'hFE02, 16'h0000, 0, 0, 8'h00, rd);
        check("kb_int_clear", {31'd0, o_KB_INT}, 32'd0);

        // KBDR read coinciding with a new character
        kb_char(8'h60);
        op(0, 16'hFE02, 16'h0000, 0, 1, 8'h61, rd);
        check("kbdr_coincide", {16'd0, rd}, 32'h0060);
        op(0, 16'hFE00, 16'h0000, 0, 0, 8'h00, rd);
        check("kbsr_coincide", {16'd0, rd}, 32'hC000);

        // Abort in ACCESS cycle 1 of a KBDR read (buffer still full)
        i_MIO_EN = 1; i_R_W = 0; i_MAR = 16'hFE02;
        @(posedge clk); #1;
        i_MIO_EN = 0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (o_R_Bit !== 1'b0) seen = 1;
        end
        check("abort_rbit", {31'd0, seen}, 32'd0);
        op(0, 16'hFE00, 16'h0000, 0, 0, 8'h00, rd);
        check("abort_kbsr", {16'd0, rd}, 32'hC000);

        // Randomized traffic
        addrs[0] = 16'hFE00; addrs[1] = 16'hFE02; addrs[2] = 16'hFE04;
        addrs[3] = 16'hFE06; addrs[4] = 16'hFE08; addrs[5] = 16'hFFFE;
        addrs[6] = 16'hFDFF; addrs[7] = 16'hFE01;
        for (int it = 0; it < 150; it++) begin
            logic [15:0] a;
            n = $urandom_range(0, 9);
            a = ($urandom_range(0, 4) == 0) ? 16'hFDFF : (16'h3000 + 16'($urandom_range(0, 15)));
            case (n)
                0, 1, 2: op(1, a, 16'($urandom), $urandom_range(0, 2), 0, 8'h00, rd);
                3, 4, 5: op(0, a, 16'h0000, $urandom_range(0, 2), 0, 8'h00, rd);
                6: op(0, addrs[$urandom_range(0, 7)], 16'h0000, 0,
                      ($urandom_range(0, 3) == 0), 8'($urandom), rd);
                7: op(1, addrs[$urandom_range(0, 7)], 16'($urandom), 0, 0, 8'h00, rd);
                8: kb_char(8'($urandom));
                default: ddr_ack();
            endcase
        end

        // Reset while in DONE
        op(1, 16'hFE06, 16'h0077, 0, 0, 8'h00, rd);
        i_MIO_EN = 1; i_R_W = 0; i_MAR = 16'h3000;
        n = 0;
        while (o_R_Bit !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        check("pre_reset_rbit", {31'd0, o_R_Bit}, 32'd1);
        i_Reset = 1;
        @(posedge clk); #1;
        i_Reset = 0; i_MIO_EN = 0;
        model_reset();
        check("reset_rbit", {31'd0, o_R_Bit}, 32'd0);
        check("reset_mem_data", {16'd0, o_Mem_Data}, 32'd0);
        check_side();
        op(0, 16'hFE04, 16'h0000, 0, 0, 8'h00, rd);
        check("reset_dsr", {16'd0, rd}, 32'h8000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_memory_io
`default_nettype wire

// File: doc/memory_io.md
Name: memory_io

Overview:
LC-3 memory/IO responder. It is the other end of the microsequencer's MIO_EN/R handshake.
- Accepts a memory access request (MAR, MDR, R_W) from the datapath.
- Performs the access against a synchronous RAM or the memory-mapped device registers (KBSR/KBDR/DSR/DDR).
- Raises o_R_Bit when the access completes.
- Supplies read data to the MDR input mux and the keyboard interrupt request to interrupt control.

Parameters:
WAIT_STATES, 2, number of ACCESS-state cycles per access; legal range 2..15; minimum 2 covers the 1-cycle RAM read latency.
ADDR_W, 16, address width.
DATA_W, 16, data width.

Ports:
i_CLK  in  1  system clock
i_Reset  in  1  reset; synchronous, active-high
i_MIO_EN  in  1  access request; held high by control until R observed
i_R_W  in  1  1 = write, 0 = read
i_MAR  in  16  access address
i_MDR  in  16  write data
o_R_Bit  out  1  access complete (ready) to microsequencer
o_Mem_Data  out  16  read data to MDR mux
o_Mem_EN  out  1  RAM enable strobe
o_Mem_WE  out  1  RAM write enable
o_Mem_Addr  out  16  RAM address
o_Mem_Wdata  out  16  RAM write data
i_Mem_Rdata  in  16  RAM read data; valid one cycle after o_Mem_EN
i_KB_Valid  in  1  keyboard character strobe
i_KB_Data  in  8  keyboard character
o_DDR_Valid  out  1  display character valid
o_DDR_Data  out  8  display character
i_DDR_Ready  in  1  display accepts character
o_KB_INT  out  1  KBSR[15] & KBSR[14]

Behaviour:
Reset and decode:
- Reset values (synchronous, i_Reset high at posedge): state IDLE; o_R_Bit=0; o_Mem_EN=0; o_Mem_WE=0; o_Mem_Data=0; KBSR=0; KBDR=0; DSR[15]=1; o_DDR_Valid=0; o_DDR_Data=0; counter=0.
- Reset mid-access aborts the access. No device side effects occur.
- Device page: MAR[15:9]==7'h7F (xFE00-xFFFF). It never touches RAM.
- Register map: KBSR xFE00, KBDR xFE02, DSR xFE04, DDR xFE06. Other device-page addresses read 0; writes to them are ignored.

FSM (IDLE, ACCESS, DONE):
- IDLE: when i_MIO_EN=1, latch MAR/MDR/R_W and the device flag, load counter=WAIT_STATES, go to ACCESS.
- ACCESS:
  - o_Mem_EN=1 in the first ACCESS cycle only, and only for non-device addresses.
  - o_Mem_WE=latched R_W in that same cycle.
  - o_Mem_Addr and o_Mem_Wdata present the latched values throughout ACCESS.
  - The counter decrements each cycle.
  - In the last cycle (counter==1), capture read data into o_Mem_Data: RAM → i_Mem_Rdata; device → selected register zero-extended. Commit device side effects in the same cycle, then go to DONE.
- DONE: o_R_Bit=1 (registered). Stay while i_MIO_EN=1; go to IDLE when i_MIO_EN=0. o_R_Bit clears on the IDLE transition.

Timing and abort:
- Latency: i_MIO_EN first high in cycle 0 → ACCESS cycles 1..WAIT_STATES → o_R_Bit=1 from cycle WAIT_STATES+1. Timing is identical for RAM and device accesses.
- If i_MIO_EN drops during ACCESS: return to IDLE, o_R_Bit stays 0, no device side effects. A RAM write strobed in ACCESS cycle 1 is not revoked.
- Back-to-back: a new request is accepted only from IDLE, so there is a minimum 1 IDLE cycle between accesses.

Keyboard:
- i_KB_Valid while KBSR[15]=0 → KBDR={8'h00,i_KB_Data}, KBSR[15]=1.
- i_KB_Valid while KBSR[15]=1 → character dropped (overrun), KBDR unchanged.
- Read-commit of KBDR clears KBSR[15].
- If that commit coincides with i_KB_Valid: new character loaded, KBSR[15] stays 1.
- Write to KBSR updates bit 14 only.

Display:
- Write-commit to DDR while DSR[15]=1 → o_DDR_Data=MDR[7:0], o_DDR_Valid=1, DSR[15]=0.
- Write to DDR while DSR[15]=0 is ignored.
- o_DDR_Valid & i_DDR_Ready at a posedge → o_DDR_Valid=0, DSR[15]=1.
- DSR and KBDR are read-only; writes to them are ignored.

Decomposition:
- Package lc3_mem_pkg: device addresses (KBSR/KBDR/DSR/DDR), device-page prefix 7'h7F, FSM state encoding, R_W encoding constants.
- Sub-module io_device_regs: KBSR/KBDR/DSR/DDR storage, keyboard capture, display handshake, read mux, o_KB_INT. It is driven by a one-cycle commit strobe, the latched address, R_W and MDR from memory_io.

Test Plan:
- RAM read, WAIT_STATES=2, MAR=x3000, RAM holds x1234: MIO_EN high cycle 0 → o_Mem_EN only in cycle 1; o_R_Bit=1 from cycle 3; o_Mem_Data=x1234; MIO_EN low in cycle 4 → o_R_Bit=0 in cycle 5.
- RAM write MAR=x4000, MDR=xBEEF: exactly one o_Mem_EN/o_Mem_WE pulse with Addr=x4000, Wdata=xBEEF; o_R_Bit from cycle 3; a subsequent read returns xBEEF.
- Keyboard: i_KB_Valid with x41 → read KBSR returns x8000. Read KBDR returns x0041 and KBSR[15]=0. Second i_KB_Valid x42 before the KBDR read → KBDR stays x0041.
- Display: write DDR=x0058 → o_DDR_Valid=1, o_DDR_Data=x58, DSR reads x0000. Second DDR write x0059 is ignored. i_DDR_Ready → DSR reads x8000.
- Interrupt: write KBSR=x4000, then i_KB_Valid → o_KB_INT=1. Read KBDR → o_KB_INT=0.
- Abort/reset: drop MIO_EN in ACCESS cycle 1 of a KBDR read → KBSR[15] unchanged, o_R_Bit never rises. Assert i_Reset in DONE → next cycle o_R_Bit=0, state IDLE, DSR reads x8000.
